apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
//  APB master that shares one APB bus (SPI register slave) among NREQ requesters.
//  Round-robin arbitration; one transfer in flight; generates SETUP/ACCESS phases and returns a per-requester response.
//  Sits between the CPU/DMA-side command sources and the apb_intf-connected SPI peripheral.
// PARAMETERS
//  AWIDTH   4   APB address width
//  DWIDTH   8   APB data width
//  NREQ     2   number of requesters (>=2)
//  TIMEOUT  16  ACCESS-phase wait limit in cycles (used only with APB_TIMEOUT_EN)
// PORTS
//  PCLK       in   1             clock, all logic on rising edge
//  PRESET     in   1             reset, synchronous, active-high
//  req_valid  in   NREQ          request pending; held until req_ready
//  req_write  in   NREQ          1=write, 0=read
//  req_addr   in   NREQ*AWIDTH   address, requester i at [i*AWIDTH +: AWIDTH]
//  req_wdata  in   NREQ*DWIDTH   write data, same packing
//  req_ready  out  NREQ          one-hot 1-cycle accept pulse
//  rsp_valid  out  NREQ          one-hot 1-cycle completion pulse to the owning requester
//  rsp_rdata  out  DWIDTH        read data, valid with rsp_valid (0 for writes)
//  rsp_err    out  1             PSLVERR, or timeout, valid with rsp_valid
//  PSEL, PENABLE, PWRITE  out 1 ; PADDR out AWIDTH ; PWDATA out DWIDTH   APB master outputs
//  PRDATA in DWIDTH ; PREADY in 1 ; PSLVERR in 1                           APB slave returns
// BEHAVIOUR
//  Reset (sync): all outputs 0; FSM=IDLE; rr pointer -> requester 0 has top priority; in-flight transfer dropped, no rsp.
//  FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
//   IDLE: if any req_valid, grant = first set bit searching from (last_grant+1) mod NREQ;
//         req_ready[grant]=1 this cycle (combinational from registered state + req_valid); latch write/addr/wdata; -> SETUP.
//   SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched values; -> ACCESS.
//   ACCESS: PSEL=1, PENABLE=1; on PREADY=1 capture PRDATA (reads) and PSLVERR; -> DONE. PREADY=0: stay.
//   DONE: PSEL=PENABLE=0; rsp_valid[grant]=1, rsp_rdata/rsp_err registered; update last_grant=grant; -> IDLE.
//  Latency: accept (cycle 0) -> SETUP (1) -> ACCESS (2, PREADY=1) -> rsp_valid (3). Max throughput 1 per 4 cycles.
//  PADDR/PWRITE/PWDATA stable through SETUP+ACCESS; hold last value outside transfers.
//  req_valid deasserting in IDLE before accept: no grant. Changes after accept: ignored (values latched).
//  Simultaneous requests: exactly one req_ready; losers wait, served in rr order, no starvation (wait <= NREQ-1 transfers).
//  Single requester repeatedly valid: re-granted every 4 cycles.
//  rsp_rdata = 0 and PRDATA ignored for writes; rsp_err = PSLVERR sampled with PREADY.
// CONFIGURATION
//  APB_TIMEOUT_EN defined: 
//   - cycle counter runs in ACCESS.
//   - if PREADY still 0 on the TIMEOUT-th ACCESS cycle, the transfer aborts: -> DONE, rsp_err=1, rsp_rdata=0.
//   - counter clears on entry to ACCESS.
//  APB_TIMEOUT_EN undefined: ACCESS waits on PREADY indefinitely; TIMEOUT unused; no counter logic.
// TESTING
//  1 reset mid-ACCESS (PRESET high 1 cycle) -> next cycle PSEL=PENABLE=0, no rsp_valid, req 0 has priority.
//  2 req0 write addr=4'h3 wdata=8'hA5, PREADY=1 -> SETUP cyc1, ACCESS cyc2, rsp_valid=2'b01 cyc3, rsp_err=0.
//  3 req0, req1 both valid continuously -> grant order 0,1,0,1; req_ready pulses every 4 cycles.
//  4 req1 read addr=4'h7, PREADY=0 for 3 ACCESS cycles, PRDATA=8'h5C, PSLVERR=1 -> rsp_valid=2'b10, rdata=8'h5C, err=1.
//  5 APB_TIMEOUT_EN, TIMEOUT=16, PREADY stuck 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0; without macro: still in ACCESS at 100 cycles.
//  6 req0 drops valid before accept while req1 valid -> only req1 granted; PADDR/PWDATA unchanged across SETUP/ACCESS.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin APB master sharing one APB bus among NREQ requesters.
// Optional ACCESS-phase timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DWIDTH-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [AWIDTH-1:0]        PADDR,
  output logic [DWIDTH-1:0]        PWDATA,
  input  logic [DWIDTH-1:0]        PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERR
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || TIMEOUT < 1) begin : g_param_chk
    $error("apb_master_arbiter: NREQ must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state, state_nxt;

  logic [GW-1:0] last_grant, grant, pick, idx;
  logic          any_req;
  logic          tmo;
  logic [NREQ-1:0][AWIDTH-1:0] addr_v;
  logic [NREQ-1:0][DWIDTH-1:0] wdata_v;

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;

  // Walk from the farthest offset down so the nearest requester after last_grant wins.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = GW'((int'(last_grant) + 1 + k) % NREQ);
      if (req_valid[idx]) begin
        pick    = idx;
        any_req = 1'b1;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] acc_cnt;

  // acc_cnt counts completed ACCESS cycles; abort on the TIMEOUT-th one if still stalled.
  assign tmo = (state == ACCESS) && !PREADY && (acc_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET || state != ACCESS) acc_cnt <= '0;
    else                           acc_cnt <= acc_cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs are forced low while PRESET is high.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    if (!PRESET) begin
      PSEL    = (state == SETUP) || (state == ACCESS);
      PENABLE = (state == ACCESS);
      if (state == IDLE && any_req) req_ready[pick]  = 1'b1;
      if (state == DONE)            rsp_valid[grant] = 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      last_grant <= GW'(NREQ - 1);
      grant      <= '0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        grant  <= pick;
        PWRITE <= req_write[pick];
        PADDR  <= addr_v[pick];
        PWDATA <= wdata_v[pick];
      end
      if (state == ACCESS && (PREADY || tmo)) begin
        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
        rsp_err   <= PREADY ? PSLVERR : 1'b1;
      end
      if (state == DONE) last_grant <= grant;
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin/APB-phase reference model.
module tb_apb_master_arbiter;
  localparam int AW = 4, DW = 8, NR = 2, TMO = 16;

  logic PCLK = 1'b0;
  logic PRESET;
  logic [NR-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, PWDATA, PRDATA;
  logic [AW-1:0]    PADDR;
  logic rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  int pass_cnt = 0, tot_cnt = 0;

  apb_master_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .NREQ(NR), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));

  always #5 PCLK = ~PCLK;

  // Inputs change at the falling edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(negedge PCLK);
  endtask

  task automatic do_reset();
    cyc(); PRESET = 1'b1; req_valid = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    cyc(); PRESET = 1'b0;
  endtask

  task automatic test_reset();
    cyc(); PRESET = 1'b1; req_valid = 2'b11; PREADY = 1'b1; #1;
    tot_cnt++; if ({req_ready, rsp_valid, PSEL, PENABLE} !== 6'b0)
      $display("FAIL reset_comb: got %b want 000000", {req_ready, rsp_valid, PSEL, PENABLE}); else pass_cnt++;
    cyc(); #1;
    tot_cnt++; if ({PWRITE, PADDR, PWDATA, rsp_rdata, rsp_err} !== '0)
      $display("FAIL reset_regs: got %h want 0", {PWRITE, PADDR, PWDATA, rsp_rdata, rsp_err}); else pass_cnt++;
    // reset in the middle of ACCESS
    cyc(); PRESET = 1'b0; req_valid = 2'b10; req_write = 2'b00; req_addr = {4'h7, 4'h1}; PREADY = 1'b0; #1;
    tot_cnt++; if (req_ready !== 2'b10) $display("FAIL rst_acc_grant: got %b want 10", req_ready); else pass_cnt++;
    cyc(); req_valid = 2'b00;
    cyc(); #1;
    tot_cnt++; if ({PSEL, PENABLE} !== 2'b11) $display("FAIL rst_acc_in_access: got %b want 11", {PSEL, PENABLE}); else pass_cnt++;
    cyc(); PRESET = 1'b1;
    cyc(); PRESET = 1'b0; req_valid = 2'b11; #1;
    tot_cnt++; if ({PSEL, PENABLE, rsp_valid} !== 4'b0000)
      $display("FAIL rst_acc_dropped: got %b want 0000", {PSEL, PENABLE, rsp_valid}); else pass_cnt++;
    tot_cnt++; if (req_ready !== 2'b01) $display("FAIL rst_acc_prio: got %b want 01", req_ready); else pass_cnt++;
  endtask

  task automatic test_single_write();
    do_reset();
    cyc(); req_valid = 2'b01; req_write = 2'b01; req_addr = {4'h0, 4'h3}; req_wdata = {8'h00, 8'hA5};
    PREADY = 1'b1; PRDATA = 8'hFF; PSLVERR = 1'b0; #1;
    tot_cnt++; if (req_ready !== 2'b01) $display("FAIL wr_accept: got %b want 01", req_ready); else pass_cnt++;
    cyc(); req_valid = 2'b00; #1;
    tot_cnt++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 4'h3, 8'hA5})
      $display("FAIL wr_setup: got %h want %h", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 4'h3, 8'hA5}); else pass_cnt++;
    cyc(); #1;
    tot_cnt++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b111, 4'h3, 8'hA5})
      $display("FAIL wr_access: got %h want %h", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b111, 4'h3, 8'hA5}); else pass_cnt++;
    cyc(); #1;
    tot_cnt++; if ({rsp_valid, rsp_rdata, rsp_err, PSEL} !== {2'b01, 8'h00, 1'b0, 1'b0})
      $display("FAIL wr_rsp: got %h want %h", {rsp_valid, rsp_rdata, rsp_err, PSEL}, {2'b01, 8'h00, 2'b00}); else pass_cnt++;
    cyc(); #1;
    tot_cnt++; if (rsp_valid !== 2'b00) $display("FAIL wr_rsp_pulse: got %b want 00", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [1:0] er, ev;
    do_reset();
    cyc(); req_valid = 2'b11; req_write = 2'b11; req_addr = {4'h2, 4'h1}; req_wdata = {8'h22, 8'h11};
    PREADY = 1'b1; PSLVERR = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) cyc();
      #1;
      er = (c % 4 == 0) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      ev = (c % 4 == 3) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      tot_cnt++; if (req_ready !== er) $display("FAIL rr_ready c=%0d: got %b want %b", c, req_ready, er); else pass_cnt++;
      tot_cnt++; if (rsp_valid !== ev) $display("FAIL rr_rsp c=%0d: got %b want %b", c, rsp_valid, ev); else pass_cnt++;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_read_wait_err();
    do_reset();
    cyc(); req_valid = 2'b10; req_write = 2'b00; req_addr = {4'h7, 4'h0};
    PREADY = 1'b0; PRDATA = 8'h11; PSLVERR = 1'b1; #1;
    tot_cnt++; if (req_ready !== 2'b10) $display("FAIL rd_accept: got %b want 10", req_ready); else pass_cnt++;
    cyc(); req_valid = 2'b00; #1;
    tot_cnt++; if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b100, 4'h7})
      $display("FAIL rd_setup: got %h want %h", {PSEL, PENABLE, PWRITE, PADDR}, {3'b100, 4'h7}); else pass_cnt++;
    for (int w = 0; w < 3; w++) begin
      cyc(); #1;
      tot_cnt++; if ({PSEL, PENABLE, rsp_valid} !== 4'b1100)
        $display("FAIL rd_wait w=%0d: got %b want 1100", w, {PSEL, PENABLE, rsp_valid}); else pass_cnt++;
    end
    cyc(); PREADY = 1'b1; PRDATA = 8'h5C; #1;
    tot_cnt++; if ({PSEL, PENABLE} !== 2'b11) $display("FAIL rd_ready_cyc: got %b want 11", {PSEL, PENABLE}); else pass_cnt++;
    cyc(); PREADY = 1'b0; PRDATA = 8'h11; #1;
    tot_cnt++; if ({rsp_valid, rsp_rdata, rsp_err} !== {2'b10, 8'h5C, 1'b1})
      $display("FAIL rd_rsp: got %h want %h", {rsp_valid, rsp_rdata, rsp_err}, {2'b10, 8'h5C, 1'b1}); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    cyc(); req_valid = 2'b01; req_write = 2'b00; req_addr = {4'h0, 4'h9}; PREADY = 1'b0; PRDATA = 8'hEE; PSLVERR = 1'b0;
    cyc(); req_valid = 2'b00;
`ifdef APB_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      cyc(); #1;
      tot_cnt++; if ({PSEL, PENABLE, rsp_valid} !== 4'b1100)
        $display("FAIL tmo_access k=%0d: got %b want 1100", k, {PSEL, PENABLE, rsp_valid}); else pass_cnt++;
    end
    cyc(); #1;
    tot_cnt++; if ({rsp_valid, rsp_rdata, rsp_err} !== {2'b01, 8'h00, 1'b1})
      $display("FAIL tmo_abort: got %h want %h", {rsp_valid, rsp_rdata, rsp_err}, {2'b01, 8'h00, 1'b1}); else pass_cnt++;
`else
    n = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(); #1;
      if ({PSEL, PENABLE, rsp_valid} === 4'b1100) n++;
    end
    tot_cnt++; if (n != 100) $display("FAIL no_tmo_wait: in-access cycles %0d want 100", n); else pass_cnt++;
`endif
  endtask

  task automatic test_drop();
    do_reset();
    cyc(); req_valid = 2'b11; req_write = 2'b11; req_addr = {4'hB, 4'h5}; req_wdata = {8'h3C, 8'h77};
    PREADY = 1'b0; PSLVERR = 1'b0; #1;
    tot_cnt++; if (req_ready !== 2'b01) $display("FAIL drop_pre: got %b want 01", req_ready); else pass_cnt++;
    #2; req_valid = 2'b10; #1;
    tot_cnt++; if (req_ready !== 2'b10) $display("FAIL drop_grant: got %b want 10", req_ready); else pass_cnt++;
    cyc(); req_addr = {4'h0, 4'hF}; req_wdata = '0; req_valid = 2'b11; #1;
    tot_cnt++; if ({PSEL, PENABLE, PADDR, PWDATA, req_ready} !== {2'b10, 4'hB, 8'h3C, 2'b00})
      $display("FAIL drop_setup: got %h want %h", {PSEL, PENABLE, PADDR, PWDATA, req_ready}, {2'b10, 4'hB, 8'h3C, 2'b00}); else pass_cnt++;
    cyc(); #1;
    tot_cnt++; if ({PSEL, PENABLE, PADDR, PWDATA} !== {2'b11, 4'hB, 8'h3C})
      $display("FAIL drop_access: got %h want %h", {PSEL, PENABLE, PADDR, PWDATA}, {2'b11, 4'hB, 8'h3C}); else pass_cnt++;
    cyc(); PREADY = 1'b1; #1;
    tot_cnt++; if ({PSEL, PENABLE, PADDR, PWDATA} !== {2'b11, 4'hB, 8'h3C})
      $display("FAIL drop_access2: got %h want %h", {PSEL, PENABLE, PADDR, PWDATA}, {2'b11, 4'hB, 8'h3C}); else pass_cnt++;
    cyc(); req_valid = 2'b00; PREADY = 1'b0; #1;
    tot_cnt++; if (rsp_valid !== 2'b10) $display("FAIL drop_rsp: got %b want 10", rsp_valid); else pass_cnt++;
    cyc(); #1;
    tot_cnt++; if ({PSEL, PADDR, PWDATA} !== {1'b0, 4'hB, 8'h3C})
      $display("FAIL drop_hold: got %h want %h", {PSEL, PADDR, PWDATA}, {1'b0, 4'hB, 8'h3C}); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [NR-1:0] pend, p_write, exp_ready, exp_rsp;
    logic [AW-1:0] p_addr [NR];
    logic [DW-1:0] p_wdata [NR];
    logic          t_write, e_err, exp_sel, exp_en, active, fin, took;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, e_rd;
    int last, g, age, ix;
    do_reset();
    pend = '0; p_write = '0; last = NR - 1; active = 1'b0; fin = 1'b0; age = 0; g = 0;
    t_write = 1'b0; t_addr = '0; t_wdata = '0; e_rd = '0; e_err = 1'b0;
    for (int i = 0; i < NR; i++) begin p_addr[i] = '0; p_wdata[i] = '0; end
    for (int c = 0; c < 500; c++) begin
      cyc();
      for (int i = 0; i < NR; i++)
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1; p_write[i] = 1'($urandom); p_addr[i] = AW'($urandom); p_wdata[i] = DW'($urandom);
        end
      req_valid = pend; req_write = p_write;
      for (int i = 0; i < NR; i++) begin req_addr[i*AW +: AW] = p_addr[i]; req_wdata[i*DW +: DW] = p_wdata[i]; end
      PREADY = ($urandom_range(3) != 0); PRDATA = DW'($urandom); PSLVERR = ($urandom_range(3) == 0);
      #1;
      exp_ready = '0; exp_rsp = '0; exp_sel = 1'b0; exp_en = 1'b0; took = 1'b0;
      if (!active) begin
        if (pend != '0) begin
          g = -1;
          for (int k = 0; k < NR; k++) begin
            ix = (last + 1 + k) % NR;
            if (g < 0 && pend[ix]) g = ix;
          end
          exp_ready[g] = 1'b1; took = 1'b1; active = 1'b1; age = 0; fin = 1'b0;
          t_write = p_write[g]; t_addr = p_addr[g]; t_wdata = p_wdata[g];
        end
      end else begin
        age++;
        if (fin) exp_rsp[g] = 1'b1;
        else if (age == 1) exp_sel = 1'b1;
        else begin
          exp_sel = 1'b1; exp_en = 1'b1;
          if (PREADY) begin fin = 1'b1; e_rd = t_write ? '0 : PRDATA; e_err = PSLVERR; end
`ifdef APB_TIMEOUT_EN
          else if (age - 1 == TMO) begin fin = 1'b1; e_rd = '0; e_err = 1'b1; end
`endif
        end
      end
      tot_cnt++; if (req_ready !== exp_ready) $display("FAIL rnd_ready c=%0d: got %b want %b", c, req_ready, exp_ready); else pass_cnt++;
      tot_cnt++; if (rsp_valid !== exp_rsp) $display("FAIL rnd_rsp c=%0d: got %b want %b", c, rsp_valid, exp_rsp); else pass_cnt++;
      tot_cnt++; if ({PSEL, PENABLE} !== {exp_sel, exp_en})
        $display("FAIL rnd_phase c=%0d: got %b want %b", c, {PSEL, PENABLE}, {exp_sel, exp_en}); else pass_cnt++;
      if (exp_sel) begin
        tot_cnt++; if ({PWRITE, PADDR, PWDATA} !== {t_write, t_addr, t_wdata})
          $display("FAIL rnd_bus c=%0d: got %h want %h", c, {PWRITE, PADDR, PWDATA}, {t_write, t_addr, t_wdata}); else pass_cnt++;
      end
      if (exp_rsp != '0) begin
        tot_cnt++; if ({rsp_rdata, rsp_err} !== {e_rd, e_err})
          $display("FAIL rnd_data c=%0d: got %h want %h", c, {rsp_rdata, rsp_err}, {e_rd, e_err}); else pass_cnt++;
        last = g; active = 1'b0;
      end
      if (took) pend[g] = 1'b0;
    end
    req_valid = '0;
  endtask

  initial begin
    PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_wait_err();
    test_timeout();
    test_drop();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
